// File: rtl/addr_gen_if.sv
// Handshake and payload bundle between operand read, the address generator, and IFU/LSU.
interface addr_gen_if #(
    parameter int unsigned XLEN = 32
) ();
    localparam int unsigned STRB_W = XLEN / 8;

    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   pc;
    logic [5:0]        ccr_flags;
    logic [XLEN-1:0]   rs1data;
    logic [XLEN-1:0]   imm_ext;
    logic [2:0]        funct3;
    logic [6:0]        opcode;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        pc_sel;
    logic [XLEN-1:0]   pc_target;
    logic [XLEN-1:0]   mem_addr;
    logic [STRB_W-1:0] mem_be;
    logic              mem_re;
    logic              mem_we;
    logic              mem_sext;
    logic              misalign;

    modport master (
        output in_valid, pc, ccr_flags, rs1data, imm_ext, funct3, opcode, out_ready,
        input  in_ready, out_valid, pc_sel, pc_target, mem_addr, mem_be,
               mem_re, mem_we, mem_sext, misalign
    );

    modport slave (
        input  in_valid, pc, ccr_flags, rs1data, imm_ext, funct3, opcode, out_ready,
        output in_ready, out_valid, pc_sel, pc_target, mem_addr, mem_be,
               mem_re, mem_we, mem_sext, misalign
    );
endinterface

// File: rtl/addr_gen_unit.sv
// Next-PC / load-store address generator with a 2-entry registered result buffer.
// The buffer head drives the outputs directly, so every output is a flop.
module addr_gen_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned COMPRESSED = 0,
    parameter int unsigned STRB_W     = XLEN / 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    addr_gen_if.slave  bus
);
    localparam int unsigned OFFW = $clog2(STRB_W);

    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] PC_4    = 2'b01;
    localparam logic [1:0] PC_ARB  = 2'b10;
    localparam logic [1:0] PC_TRAP = 2'b11;

    typedef struct packed {
        logic [1:0]        pc_sel;
        logic [XLEN-1:0]   pc_target;
        logic [XLEN-1:0]   mem_addr;
        logic [STRB_W-1:0] mem_be;
        logic              mem_re;
        logic              mem_we;
        logic              mem_sext;
        logic              misalign;
    } res_t;

    res_t            res_c;
    logic [XLEN-1:0] sum_pc;
    logic [XLEN-1:0] ea;
    logic [XLEN-1:0] tgt;
    logic            jump;
    logic            taken;
    logic            acc;
    logic            is_ld;
    logic            bad;
    logic            tmis;
    logic [2:0]      amask;
    logic [7:0]      base8;

    // Result for the instruction currently presented on the input
    always_comb begin
        res_c  = '0;
        tgt    = '0;
        jump   = 1'b0;
        taken  = 1'b0;
        acc    = 1'b0;
        is_ld  = 1'b0;
        bad    = 1'b0;
        sum_pc = bus.pc + bus.imm_ext;
        ea     = bus.rs1data + bus.imm_ext;
        res_c.mem_addr = ea;
        res_c.pc_sel   = PC_4;

        case (bus.opcode)
            OP_JAL: begin
                jump = 1'b1;
                tgt  = sum_pc;
            end
            OP_JALR: begin
                jump = 1'b1;
                tgt  = {ea[XLEN-1:1], 1'b0};
            end
            OP_BR: begin
                case (bus.funct3)
                    3'b000:  taken = bus.ccr_flags[5];
                    3'b001:  taken = bus.ccr_flags[4];
                    3'b100:  taken = bus.ccr_flags[3];
                    3'b101:  taken = bus.ccr_flags[2];
                    3'b110:  taken = bus.ccr_flags[1];
                    3'b111:  taken = bus.ccr_flags[0];
                    default: taken = 1'b0;
                endcase
                jump = taken;
                tgt  = sum_pc;
            end
            OP_LOAD: begin
                acc   = 1'b1;
                is_ld = 1'b1;
                bad   = (XLEN == 32) && ((bus.funct3[1:0] == 2'b11) || (bus.funct3 == 3'b110));
            end
            OP_STORE: begin
                acc = 1'b1;
                bad = bus.funct3[2] || ((XLEN == 32) && (bus.funct3[1:0] == 2'b11));
            end
            default: ;
        endcase

        case (bus.funct3[1:0])
            2'b00:   begin amask = 3'b000; base8 = 8'h01; end
            2'b01:   begin amask = 3'b001; base8 = 8'h03; end
            2'b10:   begin amask = 3'b011; base8 = 8'h0F; end
            default: begin amask = 3'b111; base8 = 8'hFF; end
        endcase

        tmis = (COMPRESSED != 0) ? tgt[0] : (tgt[1] | tgt[0]);

        if (jump) begin
            res_c.pc_target = tgt;
            res_c.pc_sel    = tmis ? PC_TRAP : PC_ARB;
            res_c.misalign  = tmis;
        end

        if (acc) begin
            if (bad) begin
                res_c.pc_sel = PC_TRAP;
            end else if (|(ea[2:0] & amask)) begin
                res_c.pc_sel   = PC_TRAP;
                res_c.misalign = 1'b1;
            end else begin
                res_c.mem_be   = STRB_W'(base8) << ea[OFFW-1:0];
                res_c.mem_re   = is_ld;
                res_c.mem_we   = ~is_ld;
                res_c.mem_sext = is_ld & ~bus.funct3[2];
            end
        end
    end

    logic [1:0] cnt_q, cnt_d;
    res_t       head_q, head_d;
    res_t       sec_q, sec_d;
    logic       in_rdy_q;
    logic       out_vld_q;
    logic       push;
    logic       pop;

    // Two-entry shift buffer: head is the visible entry, sec queues behind it
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        sec_d  = sec_q;
        push   = bus.in_valid & in_rdy_q;
        pop    = out_vld_q & bus.out_ready;

        if (flush) begin
            cnt_d  = 2'd0;
            head_d = '0;
            sec_d  = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_d = res_c;
                    else               sec_d  = res_c;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    head_d = (cnt_q == 2'd2) ? sec_q : '0;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_d = res_c;
                    end else begin
                        head_d = sec_q;
                        sec_d  = res_c;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= 2'd0;
            head_q    <= '0;
            sec_q     <= '0;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            sec_q     <= sec_d;
            in_rdy_q  <= (cnt_d < 2'd2);
            out_vld_q <= (cnt_d != 2'd0);
        end
    end

    assign bus.in_ready  = in_rdy_q;
    assign bus.out_valid = out_vld_q;
    assign bus.pc_sel    = head_q.pc_sel;
    assign bus.pc_target = head_q.pc_target;
    assign bus.mem_addr  = head_q.mem_addr;
    assign bus.mem_be    = head_q.mem_be;
    assign bus.mem_re    = head_q.mem_re;
    assign bus.mem_we    = head_q.mem_we;
    assign bus.mem_sext  = head_q.mem_sext;
    assign bus.misalign  = head_q.misalign;
endmodule

// File: doc/addr_gen_unit.md
Name: addr_gen_unit

Overview:
- Registered, parametrised next-PC and memory-address generator for the RV32/RV64 integer core. Sits between decode/operand-read and IFU/LSU.
- Per accepted instruction, produces the PC select and target, or the load/store effective address, byte strobes and misalignment trap.
- Decoupled from both neighbours by valid/ready handshakes and a 2-entry output buffer.
- Supports flush on redirect.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- COMPRESSED, 0, 1 = 2-byte instruction alignment, 0 = 4-byte alignment for jump/branch targets.
- STRB_W, XLEN/8, byte-strobe width (derived; do not override).

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  discard all buffered and incoming work
- in_valid  in  1  input payload valid
- in_ready  out  1  unit can accept payload
- pc  in  XLEN  instruction PC
- ccr_flags  in  6  EQ|NE|LT|GE|LTU|GEU, bit 5..0
- rs1data  in  XLEN  source 1
- imm_ext  in  XLEN  sign-extended immediate
- funct3  in  3  instruction funct3
- opcode  in  7  instruction opcode
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- pc_sel  out  2  00 PC, 01 PC_4, 10 PC_ARB, 11 PC_TRAP
- pc_target  out  XLEN  redirect target (0 unless PC_ARB/PC_TRAP)
- mem_addr  out  XLEN  effective address rs1data+imm_ext
- mem_be  out  STRB_W  byte strobes
- mem_re  out  1  load
- mem_we  out  1  store
- mem_sext  out  1  load result sign-extends (LB/LH/LW on RV64)
- misalign  out  1  address/target misaligned trap

Behaviour:
- Reset: rst_n low at posedge clears buffer.
  - out_valid=0, in_ready=0 during reset; all payload outputs 0.
  - in_ready=1 on the first cycle after release.
- Buffer: 2-entry FIFO of computed results.
  - in_ready = (count<2).
  - Accept when in_valid&in_ready; pop when out_valid&out_ready.
  - Simultaneous push and pop keeps count.
  - Outputs always show the head entry, registered.
- Latency: result visible 1 cycle after accept. Full throughput (1/cycle) when out_ready held high.
- Flush: synchronous, priority over accept and pop; count := 0, out_valid=0 next cycle. An input presented in the flush cycle is dropped.
- Compute (combinational on input, registered into buffer):
  - J (1101111): pc_sel=PC_ARB, target=pc+imm_ext.
  - JALR (1100111): target=(rs1data+imm_ext)&~1, pc_sel=PC_ARB.
  - B (1100011): flag by funct3:
    - 000→EQ, 001→NE, 100→LT, 101→GE, 110→LTU, 111→GEU.
    - Taken → PC_ARB, target=pc+imm_ext; not taken → PC_4, target=0.
    - funct3 010/011 → PC_4.
  - Target alignment (taken J/JALR/B):
    - COMPRESSED=0: target[1]=1 → pc_sel=PC_TRAP, misalign=1.
    - target still reported.
  - LOAD (0000011): mem_re=1, pc_sel=PC_4.
    - Size from funct3[1:0]: 00 byte, 01 half, 10 word, 11 dword.
    - mem_sext=!funct3[2].
    - funct3 011 (LD) or 110 (LWU) legal only when XLEN=64; otherwise no access, mem_re=0, pc_sel=PC_TRAP.
  - STORE (0100011): mem_we=1, pc_sel=PC_4.
    - Size as above; funct3[2]=1 or SD with XLEN=32 → PC_TRAP, no access.
  - mem_be = {1,3,F,FF}[size] << addr[log2(STRB_W)-1:0].
  - Misaligned when addr not multiple of size → misalign=1, mem_be=0, mem_re=mem_we=0, pc_sel=PC_TRAP.
  - Other opcodes: pc_sel=PC_4, addr computed, be=0, re=we=0, misalign=0.
- Arithmetic: all sums modulo 2^XLEN; wrap-around is not an error.

Test Plan:
- Reset held 3 cycles with in_valid=1 → out_valid=0, in_ready=0. After release, in_ready=1 and the first input emerges 1 cycle after accept.
- XLEN=32, JALR rs1=0x1003, imm=0x4 → pc_target=0x1006, pc_sel=TRAP, misalign=1. With COMPRESSED=1 → pc_sel=10, misalign=0.
- BLTU pc=0x100, imm=0xFFFFFFF0, ccr=000010 → pc_sel=10, target=0xF0. Same with ccr=000001 → pc_sel=01, target=0.
- SH rs1=0x2001, imm=0x1 → addr 0x2002, mem_be=1100, mem_we=1. LW addr 0x2002 → misalign=1, mem_be=0, pc_sel=11.
- out_ready=0, push 3 back-to-back inputs → in_ready low after 2 accepts, third held. Raise out_ready → all 3 delivered in order, one per cycle.
- 2 entries buffered, flush with in_valid=1 → next cycle out_valid=0, count 0, flushed input never delivered.
